case_sel_arbiter: RTL and testbench
===================================

// Module: case_sel_arbiter
// PURPOSE
//  Round-robin arbiter/sequencer for the 6:1 case-select datapath mux.
//  - Six requesters each present a 4-bit word; block drives the 3-bit mux select and forwards the
//    selected word on a valid/ready output.
//  - Bounds each grant to HOLD_MAX beats, so one requester cannot monopolise the mux.
// PARAMETERS
//  DW        4   width of each data word and of out_data
//  HOLD_MAX  4   max accepted beats per grant (legal range 1..15)
// PORTS
//  clk        in   1     single clock, all state on rising edge
//  rst_n      in   1     reset, asynchronous, active-low
//  req        in   6     req[i]=1: requester i has a word on data_in slice i
//  data_in    in   6*DW  requester i word at data_in[i*DW +: DW]
//  out_ready  in   1     downstream accepts beat this cycle
//  out_valid  out  1     registered; out_data is valid
//  out_data   out  DW    data_in slice selected by sel (combinational from sel register)
//  sel        out  3     registered mux select, 0..5 only
//  ack        out  6     one-hot pulse, 1 cycle: beat from requester sel accepted
//  busy       out  1     1 while in XFER
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, sel=0, last=5, beat_cnt=0, out_valid=0, ack=0, busy=0.
//  States:
//  - IDLE: if |req, winner = first i with req[i]=1, scanning last+1, last+2, ... mod 6.
//    Next edge: sel<=winner, beat_cnt<=0, out_valid<=1, state<=XFER. If req==0, stay in IDLE.
//  - XFER, out_valid && out_ready (beat accepted): ack[sel]=1 for that cycle, beat_cnt++.
//    - If req[sel]=1 and beat_cnt+1<HOLD_MAX: stay in XFER (back-to-back beats, no bubble).
//    - Otherwise: last<=sel, out_valid<=0, state<=IDLE.
//  - XFER, req[sel] drops with no handshake: abort. No ack; last<=sel; out_valid<=0; state<=IDLE.
//    Handshake and req drop in the same cycle count as an accepted beat (ack pulses).
//  - XFER, out_ready=0: hold sel and out_valid. out_data follows data_in live; requesters must
//    hold their data stable while req=1.
//  Timing:
//  - Grant latency: 1 cycle from req seen in IDLE to out_valid=1.
//  - Between grants, 1 IDLE bubble cycle is mandatory.
//  - ack is registered off the handshake: ack asserts the cycle after the beat is accepted.
//  Arbitration rules:
//  - Rotation uses mod-6 wrap: after last=5 the scan starts at 0. Arbitration is fair: the
//    requester just served has lowest priority at the next arbitration.
//  - Requests raised during XFER wait for the next IDLE arbitration.
//  - A single requester with req held continuously gets HOLD_MAX beats, then IDLE, then is re-granted.
//  - beat_cnt is $clog2(HOLD_MAX+1) bits and never wraps; it is cleared on every grant.
//  - rst_n asserted mid-transfer: outputs drop immediately (async); no ack for the in-flight beat.
// CONFIGURATION
//  ARB_LOCK_EN defined:
//  - Adds input port lock[5:0].
//  - While lock[sel]=1 in XFER, the HOLD_MAX limit is ignored; the grant ends only when req[sel]
//    or lock[sel] drops after a beat, or on abort.
//  - lock is sampled only in XFER; beat_cnt saturates at HOLD_MAX.
//  ARB_LOCK_EN undefined:
//  - No lock port; the HOLD_MAX limit always applies.
// TESTING
//  1 Reset: rst_n=0 mid-XFER -> out_valid=0, ack=0, sel=0 immediately; first grant after
//    release goes to the lowest requesting index >=0.
//  2 req=6'b000100, data2=4'd2, out_ready=1 -> 1 cycle later sel=2, out_valid=1, out_data=2;
//    4 acks to requester 2, then out_valid=0 for 1 cycle.
//  3 req=6'b111111 held, out_ready=1, HOLD_MAX=1 -> sel sequence 0,1,2,3,4,5,0 with one IDLE
//    cycle between each.
//  4 Backpressure: granted sel=3, out_ready=0 for 5 cycles -> sel=3, out_valid=1, ack=0 held;
//    first ack follows out_ready=1.
//  5 Abort: sel=1 in XFER, out_ready=0, req[1] drops -> no ack, IDLE next cycle; next winner
//    is searched from index 2.
//  6 ARB_LOCK_EN defined: lock[4]=1, req[4]=1 held, out_ready=1 -> more than HOLD_MAX
//    consecutive acks to 4; lock[4] drops -> grant ends after the next beat.

Source files
------------

// File: rtl/case_sel_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : case_sel_arbiter
// Purpose  : Round-robin arbiter/sequencer driving the 6:1 case-select mux,
//            with grants bounded to HOLD_MAX accepted beats.
//            Optional macro ARB_LOCK_EN adds a per-requester lock input.
// Revision : 1.0 - initial release
// ============================================================================
module case_sel_arbiter #(
  parameter int DW       = 4,
  parameter int HOLD_MAX = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [5:0]      req,
  input  logic [6*DW-1:0] data_in,
`ifdef ARB_LOCK_EN
  input  logic [5:0]      lock,
`endif
  input  logic            out_ready,
  output logic            out_valid,
  output logic [DW-1:0]   out_data,
  output logic [2:0]      sel,
  output logic [5:0]      ack,
  output logic            busy
);

  localparam int                 c_cnt_w    = $clog2(HOLD_MAX + 1);
  localparam logic [c_cnt_w:0]   c_hold_max = (c_cnt_w + 1)'(HOLD_MAX);
  localparam logic [c_cnt_w-1:0] c_cnt_sat  = c_cnt_w'(HOLD_MAX);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_XFER = 1'b1
  } state_t;

  state_t             r_state;
  logic [2:0]         r_sel;
  logic [2:0]         r_last;
  logic [c_cnt_w-1:0] r_beat_cnt;
  logic               r_out_valid;
  logic [5:0]         r_ack;

  logic [DW-1:0]      w_words [6];
  logic [2:0]         w_idx;
  logic [2:0]         w_winner;
  logic               w_any;
  logic [c_cnt_w:0]   w_cnt_inc;
  logic               w_lock;
  logic               w_stay;

  for (genvar gi = 0; gi < 6; gi++) begin : g_unpack
    assign w_words[gi] = data_in[gi*DW +: DW];
  end

  // Scan from the farthest candidate back to last+1 so the nearest hit wins.
  always_comb begin
    w_winner = r_last;
    w_idx    = '0;
    for (int k = 6; k >= 1; k--) begin
      w_idx = 3'((int'(r_last) + k) % 6);
      if (req[w_idx]) begin
        w_winner = w_idx;
      end
    end
  end

  assign w_any     = |req;
  assign w_cnt_inc = {1'b0, r_beat_cnt} + (c_cnt_w + 1)'(1);

`ifdef ARB_LOCK_EN
  assign w_lock = lock[r_sel];
`else
  assign w_lock = 1'b0;
`endif

  // Grant continues after an accepted beat only while the requester still asks.
  assign w_stay = req[r_sel] && (w_lock || (w_cnt_inc < c_hold_max));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_sel       <= 3'd0;
      r_last      <= 3'd5;
      r_beat_cnt  <= '0;
      r_out_valid <= 1'b0;
      r_ack       <= 6'b000000;
    end else begin
      r_ack <= 6'b000000;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_sel       <= w_winner;
            r_beat_cnt  <= '0;
            r_out_valid <= 1'b1;
            r_state     <= S_XFER;
          end
        end
        S_XFER: begin
          if (r_out_valid && out_ready) begin
            r_ack <= 6'b000001 << r_sel;
            if (w_cnt_inc > c_hold_max) begin
              r_beat_cnt <= c_cnt_sat;
            end else begin
              r_beat_cnt <= w_cnt_inc[c_cnt_w-1:0];
            end
            if (!w_stay) begin
              r_last      <= r_sel;
              r_out_valid <= 1'b0;
              r_state     <= S_IDLE;
            end
          end else if (!req[r_sel]) begin
            r_last      <= r_sel;
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign sel       = r_sel;
  assign ack       = r_ack;
  assign busy      = (r_state == S_XFER);
  assign out_data  = w_words[r_sel];

endmodule
`default_nettype wire

// File: tb/tb_case_sel_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_case_sel_arbiter
// Purpose  : Scoreboarded bench for case_sel_arbiter (HOLD_MAX=4 and HOLD_MAX=1).
// Revision : 1.0 - initial release
// ============================================================================
module tb_case_sel_arbiter;

  localparam int DW = 4;

  typedef struct packed {
    logic [2:0] idx;
    logic [3:0] data;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n = 1'b1;
  logic [5:0]      req;
  logic [6*DW-1:0] data_in;
  logic            out_ready;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic [2:0]      sel;
  logic [5:0]      ack;
  logic            busy;

  logic [5:0]      req1;
  logic [6*DW-1:0] data_in1;
  logic            ready1;
  logic            valid1;
  logic [DW-1:0]   data1;
  logic [2:0]      sel1;
  logic [5:0]      ack1;
  logic            busy1;

`ifdef ARB_LOCK_EN
  logic [5:0]      lock;
  logic [5:0]      lock1;
`endif

  int   n_vec = 0;
  int   n_err = 0;
  exp_t exp_q[$];
  logic cap_vld = 1'b0;
  logic [3:0] cap_data = '0;

  case_sel_arbiter #(.DW(DW), .HOLD_MAX(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .req(req), .data_in(data_in),
`ifdef ARB_LOCK_EN
    .lock(lock),
`endif
    .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
    .sel(sel), .ack(ack), .busy(busy)
  );

  case_sel_arbiter #(.DW(DW), .HOLD_MAX(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req(req1), .data_in(data_in1),
`ifdef ARB_LOCK_EN
    .lock(lock1),
`endif
    .out_ready(ready1), .out_valid(valid1), .out_data(data1),
    .sel(sel1), .ack(ack1), .busy(busy1)
  );

  // Beat captured on the handshake; its ack is expected one clock later.
  always @(negedge clk) begin
    exp_t       e;
    logic [5:0] want;
    if (!rst_n) begin
      cap_vld = 1'b0;
    end else begin
      if (ack != 6'b000000) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL sb_unexpected_ack: got ack=%b, no beat expected", ack);
        end else begin
          e    = exp_q.pop_front();
          want = 6'b000001 << e.idx;
          if (ack !== want || !cap_vld || cap_data !== e.data) begin
            n_err++;
            $display("FAIL sb_beat: got ack=%b data=%h cap=%b, want ack=%b data=%h",
                     ack, cap_data, cap_vld, want, e.data);
          end
        end
      end
      cap_vld  = out_valid && out_ready;
      cap_data = out_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_beats(input int idx, input logic [3:0] d, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back('{idx: 3'(idx), data: d});
  endtask

  task automatic test_reset();
    req = '0; out_ready = 1'b0; req1 = '0; ready1 = 1'b0;
    data_in  = {4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0};
    data_in1 = {4'hF, 4'hE, 4'hD, 4'hC, 4'hB, 4'hA};
`ifdef ARB_LOCK_EN
    lock = '0; lock1 = '0;
`endif
    #2 rst_n = 1'b0;
    tick(); tick();
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", out_valid); end
    n_vec++; if (ack !== 6'b0) begin n_err++; $display("FAIL rst_ack: got %b want 000000", ack); end
    n_vec++; if (sel !== 3'd0) begin n_err++; $display("FAIL rst_sel: got %0d want 0", sel); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_vec++; if (valid1 !== 1'b0) begin n_err++; $display("FAIL rst_valid1: got %b want 0", valid1); end
    rst_n = 1'b1;
    req = 6'b001000;
    tick();
    n_vec++; if (sel !== 3'd3 || out_valid !== 1'b1 || busy !== 1'b1) begin
      n_err++; $display("FAIL rst_pre_grant: got sel=%0d v=%b b=%b want sel=3 v=1 b=1", sel, out_valid, busy); end
    out_ready = 1'b1;
    #5 rst_n = 1'b0;
    #1;
    n_vec++; if (out_valid !== 1'b0 || ack !== 6'b0 || sel !== 3'd0 || busy !== 1'b0) begin
      n_err++; $display("FAIL rst_async: got v=%b ack=%b sel=%0d b=%b want 0/000000/0/0", out_valid, ack, sel, busy); end
    req = 6'b001010; out_ready = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    n_vec++; if (sel !== 3'd1 || out_valid !== 1'b1) begin
      n_err++; $display("FAIL rst_first_grant: got sel=%0d v=%b want sel=1 v=1", sel, out_valid); end
    req = '0;
    tick();
    n_vec++; if (out_valid !== 1'b0 || ack !== 6'b0) begin
      n_err++; $display("FAIL rst_cleanup_abort: got v=%b ack=%b want 0/000000", out_valid, ack); end
  endtask

  task automatic test_single();
    data_in = {4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0};
    req = 6'b000100; out_ready = 1'b1;
    push_beats(2, 4'd2, 4);
    tick();
    n_vec++; if (sel !== 3'd2 || out_valid !== 1'b1 || out_data !== 4'd2) begin
      n_err++; $display("FAIL single_grant: got sel=%0d v=%b d=%0d want 2/1/2", sel, out_valid, out_data); end
    for (int k = 0; k < 3; k++) begin
      tick();
      n_vec++; if (sel !== 3'd2 || out_valid !== 1'b1) begin
        n_err++; $display("FAIL single_beat%0d: got sel=%0d v=%b want 2/1", k, sel, out_valid); end
    end
    tick();
    n_vec++; if (out_valid !== 1'b0 || ack !== 6'b000100) begin
      n_err++; $display("FAIL single_end: got v=%b ack=%b want 0/000100", out_valid, ack); end
    req = '0; out_ready = 1'b0;
    tick(); tick();
    n_vec++; if (exp_q.size() != 0 || out_valid !== 1'b0) begin
      n_err++; $display("FAIL single_drain: got pending=%0d v=%b want 0/0", exp_q.size(), out_valid); end
  endtask

  task automatic test_back_to_back();
    int exp_sel[10] = '{4, 4, 4, 4, -1, 0, 0, 0, 0, -1};
    data_in = {4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'h7};
    req = 6'b010001; out_ready = 1'b1;
    push_beats(4, 4'hB, 4);
    push_beats(0, 4'h7, 4);
    for (int i = 0; i < 10; i++) begin
      tick();
      if (exp_sel[i] < 0) begin
        n_vec++; if (out_valid !== 1'b0) begin
          n_err++; $display("FAIL b2b_bubble%0d: got v=%b want 0", i, out_valid); end
      end else begin
        n_vec++; if (out_valid !== 1'b1 || sel !== 3'(exp_sel[i]) || out_data !== (exp_sel[i] == 4 ? 4'hB : 4'h7)) begin
          n_err++; $display("FAIL b2b_cycle%0d: got v=%b sel=%0d d=%h want 1/%0d", i, out_valid, sel, out_data, exp_sel[i]); end
      end
      if (i == 9) begin req = '0; out_ready = 1'b0; end
    end
    tick(); tick();
    n_vec++; if (exp_q.size() != 0) begin
      n_err++; $display("FAIL b2b_drain: got pending=%0d want 0", exp_q.size()); end
  endtask

  task automatic test_backpressure();
    req = 6'b001000; out_ready = 1'b0;
    tick();
    n_vec++; if (sel !== 3'd3 || out_valid !== 1'b1) begin
      n_err++; $display("FAIL bp_grant: got sel=%0d v=%b want 3/1", sel, out_valid); end
    for (int k = 0; k < 5; k++) begin
      tick();
      n_vec++; if (sel !== 3'd3 || out_valid !== 1'b1 || ack !== 6'b0) begin
        n_err++; $display("FAIL bp_hold%0d: got sel=%0d v=%b ack=%b want 3/1/000000", k, sel, out_valid, ack); end
    end
    out_ready = 1'b1;
    push_beats(3, 4'hC, 1);
    tick();
    n_vec++; if (ack !== 6'b001000 || out_valid !== 1'b1) begin
      n_err++; $display("FAIL bp_first_ack: got ack=%b v=%b want 001000/1", ack, out_valid); end
    req = '0; out_ready = 1'b0;
    tick();
    n_vec++; if (out_valid !== 1'b0 || ack !== 6'b0) begin
      n_err++; $display("FAIL bp_release: got v=%b ack=%b want 0/000000", out_valid, ack); end
  endtask

  task automatic test_abort();
    req = 6'b000010; out_ready = 1'b0;
    tick();
    n_vec++; if (sel !== 3'd1 || out_valid !== 1'b1) begin
      n_err++; $display("FAIL abort_grant: got sel=%0d v=%b want 1/1", sel, out_valid); end
    req = '0;
    tick();
    n_vec++; if (out_valid !== 1'b0 || ack !== 6'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL abort_idle: got v=%b ack=%b b=%b want 0/000000/0", out_valid, ack, busy); end
    req = 6'b000101;
    tick();
    n_vec++; if (sel !== 3'd2 || out_valid !== 1'b1) begin
      n_err++; $display("FAIL abort_next_winner: got sel=%0d v=%b want 2/1", sel, out_valid); end
    req = '0; out_ready = 1'b1;
    push_beats(2, 4'hD, 1);
    tick();
    n_vec++; if (out_valid !== 1'b0 || ack !== 6'b000100) begin
      n_err++; $display("FAIL abort_drop_with_hs: got v=%b ack=%b want 0/000100", out_valid, ack); end
    out_ready = 1'b0;
    tick(); tick();
    n_vec++; if (exp_q.size() != 0) begin
      n_err++; $display("FAIL abort_drain: got pending=%0d want 0", exp_q.size()); end
  endtask

  task automatic test_rotation();
    logic [5:0] want;
    req1 = 6'b111111; ready1 = 1'b1;
    for (int g = 0; g < 7; g++) begin
      tick();
      n_vec++; if (valid1 !== 1'b1 || sel1 !== 3'(g % 6) || data1 !== 4'(10 + g % 6)) begin
        n_err++; $display("FAIL rot_grant%0d: got v=%b sel=%0d d=%h want 1/%0d", g, valid1, sel1, data1, g % 6); end
      tick();
      want = 6'b000001 << (g % 6);
      n_vec++; if (valid1 !== 1'b0 || ack1 !== want) begin
        n_err++; $display("FAIL rot_bubble%0d: got v=%b ack=%b want 0/%b", g, valid1, ack1, want); end
    end
    req1 = '0; ready1 = 1'b0;
    tick();
  endtask

`ifdef ARB_LOCK_EN
  task automatic test_lock();
    data_in = {4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'h7};
    req = 6'b010000; lock = 6'b010000; out_ready = 1'b1;
    push_beats(4, 4'hB, 8);
    tick();
    n_vec++; if (sel !== 3'd4 || out_valid !== 1'b1) begin
      n_err++; $display("FAIL lock_grant: got sel=%0d v=%b want 4/1", sel, out_valid); end
    for (int k = 0; k < 7; k++) begin
      tick();
      n_vec++; if (sel !== 3'd4 || out_valid !== 1'b1) begin
        n_err++; $display("FAIL lock_hold%0d: got sel=%0d v=%b want 4/1", k, sel, out_valid); end
    end
    lock = '0;
    tick();
    n_vec++; if (out_valid !== 1'b0 || ack !== 6'b010000) begin
      n_err++; $display("FAIL lock_release: got v=%b ack=%b want 0/010000", out_valid, ack); end
    req = '0; out_ready = 1'b0;
    tick(); tick();
    n_vec++; if (exp_q.size() != 0) begin
      n_err++; $display("FAIL lock_drain: got pending=%0d want 0", exp_q.size()); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_abort();
    test_rotation();
`ifdef ARB_LOCK_EN
    test_lock();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
